// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code decoder: strips E0/F0 prefixes, emits key events with
// ASCII translation, tracks the held key and counts make events.
// Optional macro PS2_TYPEMATIC_FILTER_EN suppresses auto-repeat make events.
module ps2_scancode_decoder #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             ev_valid,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_break,
  output logic [7:0]       ascii,
  output logic             key_down,
  output logic [CNT_W-1:0] press_cnt,
  output logic             err
);

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_make;
  logic             w_brk;
  logic             w_err;
  logic             w_ext;
  logic             w_held_match;
  logic             w_repeat;
  logic             w_make_ev;
  logic             w_event;

  logic             r_ev_valid;
  logic [7:0]       r_ev_code;
  logic             r_ev_ext;
  logic             r_ev_break;
  logic [7:0]       r_ascii;
  logic             r_key_down;
  logic [CNT_W-1:0] r_press_cnt;
  logic             r_err;
  logic [7:0]       r_held_code;
  logic             r_held_ext;

  // Set-2 code to ASCII for non-extended keys; unmapped codes give 0.
  function automatic logic [7:0] f_ascii(input logic [7:0] code);
    logic [7:0] a;
    case (code)
      8'h1C: a = 8'h41; 8'h32: a = 8'h42; 8'h21: a = 8'h43; 8'h23: a = 8'h44;
      8'h24: a = 8'h45; 8'h2B: a = 8'h46; 8'h34: a = 8'h47; 8'h33: a = 8'h48;
      8'h43: a = 8'h49; 8'h3B: a = 8'h4A; 8'h42: a = 8'h4B; 8'h4B: a = 8'h4C;
      8'h3A: a = 8'h4D; 8'h31: a = 8'h4E; 8'h44: a = 8'h4F; 8'h4D: a = 8'h50;
      8'h15: a = 8'h51; 8'h2D: a = 8'h52; 8'h1B: a = 8'h53; 8'h2C: a = 8'h54;
      8'h3C: a = 8'h55; 8'h2A: a = 8'h56; 8'h1D: a = 8'h57; 8'h22: a = 8'h58;
      8'h35: a = 8'h59; 8'h1A: a = 8'h5A;
      8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
      8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
      8'h3E: a = 8'h38; 8'h46: a = 8'h39;
      8'h29: a = 8'h20;
      8'h5A: a = 8'h0D;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Prefix decode: next state and event classification of the incoming byte.
  always_comb begin
    w_state_nxt = r_state;
    w_make      = 1'b0;
    w_brk       = 1'b0;
    w_err       = 1'b0;
    w_ext       = 1'b0;
    if (in_valid) begin
      case (r_state)
        IDLE: begin
          if (in_data == PFX_EXT)      w_state_nxt = EXT;
          else if (in_data == PFX_BRK) w_state_nxt = BRK;
          else                         w_make      = 1'b1;
        end
        EXT: begin
          w_ext = 1'b1;
          if (in_data == PFX_BRK)      w_state_nxt = EXT_BRK;
          else if (in_data == PFX_EXT) w_err       = 1'b1;
          else begin
            w_make      = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        BRK: begin
          w_state_nxt = IDLE;
          if (in_data == PFX_EXT || in_data == PFX_BRK) w_err = 1'b1;
          else                                          w_brk = 1'b1;
        end
        EXT_BRK: begin
          w_ext       = 1'b1;
          w_state_nxt = IDLE;
          if (in_data == PFX_EXT || in_data == PFX_BRK) w_err = 1'b1;
          else                                          w_brk = 1'b1;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign w_held_match = (r_held_code == in_data) && (r_held_ext == w_ext);

`ifdef PS2_TYPEMATIC_FILTER_EN
  assign w_repeat = w_make && r_key_down && w_held_match;
`else
  assign w_repeat = 1'b0;
`endif

  assign w_make_ev = w_make && !w_repeat;
  assign w_event   = w_make_ev || w_brk;

  // Registered event outputs, held-key tracking and make counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ev_valid  <= 1'b0;
      r_err       <= 1'b0;
      r_ev_code   <= 8'h00;
      r_ev_ext    <= 1'b0;
      r_ev_break  <= 1'b0;
      r_ascii     <= 8'h00;
      r_key_down  <= 1'b0;
      r_press_cnt <= '0;
      r_held_code <= 8'h00;
      r_held_ext  <= 1'b0;
    end else begin
      r_ev_valid <= w_event;
      r_err      <= w_err;
      if (w_event) begin
        r_ev_code  <= in_data;
        r_ev_ext   <= w_ext;
        r_ev_break <= w_brk;
        r_ascii    <= w_ext ? 8'h00 : f_ascii(in_data);
      end
      if (w_make) begin
        r_held_code <= in_data;
        r_held_ext  <= w_ext;
        r_key_down  <= 1'b1;
      end else if (w_brk && w_held_match) begin
        r_key_down  <= 1'b0;
      end
      if (w_make_ev) r_press_cnt <= r_press_cnt + CNT_W'(1);
    end
  end

  assign ev_valid  = r_ev_valid;
  assign ev_code   = r_ev_code;
  assign ev_ext    = r_ev_ext;
  assign ev_break  = r_ev_break;
  assign ascii     = r_ascii;
  assign key_down  = r_key_down;
  assign press_cnt = r_press_cnt;
  assign err       = r_err;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder: expected events are queued as
// bytes are driven and popped by a monitor when ev_valid or err fires.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       resetn;
  logic       in_valid;
  logic [7:0] in_data;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic [7:0] ascii;
  logic       key_down;
  logic [7:0] press_cnt;
  logic       err;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_cnt;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [7:0] asc;
    logic       is_err;
  } exp_t;

  exp_t q[$];

  logic [7:0] letters [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                               8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                               8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  logic [7:0] digits [10]  = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};

  ps2_scancode_decoder #(.CNT_W(8)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
    .ev_valid(ev_valid), .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break),
    .ascii(ascii), .key_down(key_down), .press_cnt(press_cnt), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_ascii(input logic [7:0] code, input logic ext);
    logic [7:0] a;
    a = 8'h00;
    if (!ext) begin
      for (int i = 0; i < 26; i++) if (letters[i] == code) a = 8'h41 + 8'(i);
      for (int i = 0; i < 10; i++) if (digits[i] == code)  a = 8'h30 + 8'(i);
      if (code == 8'h29) a = 8'h20;
      if (code == 8'h5A) a = 8'h0D;
    end
    return a;
  endfunction

  task automatic push_ev(input logic [7:0] code, input logic ext, input logic brk);
    exp_t e;
    e.code = code; e.ext = ext; e.brk = brk; e.asc = exp_ascii(code, ext); e.is_err = 1'b0;
    q.push_back(e);
    if (!brk) exp_cnt = exp_cnt + 8'd1;
  endtask

  task automatic push_err();
    exp_t e;
    e.code = 8'h00; e.ext = 1'b0; e.brk = 1'b0; e.asc = 8'h00; e.is_err = 1'b1;
    q.push_back(e);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (resetn && (ev_valid || err)) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output ev_valid=%0b err=%0b code=%h ext=%0b brk=%0b",
                 ev_valid, err, ev_code, ev_ext, ev_break);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.is_err) begin
          if ({ev_valid, err} !== 2'b01) begin
            bad++;
            $display("FAIL err_pulse got ev_valid=%0b err=%0b want ev_valid=0 err=1", ev_valid, err);
          end
        end else if ({ev_valid, err, ev_code, ev_ext, ev_break, ascii} !==
                     {1'b1, 1'b0, e.code, e.ext, e.brk, e.asc}) begin
          bad++;
          $display("FAIL event got v=%0b err=%0b code=%h ext=%0b brk=%0b ascii=%h want code=%h ext=%0b brk=%0b ascii=%h",
                   ev_valid, err, ev_code, ev_ext, ev_break, ascii, e.code, e.ext, e.brk, e.asc);
        end
      end
    end
  end

  task automatic drain(input string name);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s_missing_events got pending=%0d want 0", name, q.size());
    end
    q.delete();
  endtask

  task automatic test_reset();
    resetn   = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h1C;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({ev_valid, err, ev_code, ev_ext, ev_break, ascii, key_down, press_cnt} !== 29'd0) begin
      bad++;
      $display("FAIL reset_outputs got v=%0b err=%0b code=%h ext=%0b brk=%0b ascii=%h kd=%0b cnt=%h want all 0",
               ev_valid, err, ev_code, ev_ext, ev_break, ascii, key_down, press_cnt);
    end
    in_valid = 1'b0;
    resetn   = 1'b1;
    exp_cnt  = 8'd0;
    @(negedge clk);
  endtask

  task automatic test_make_break();
    push_ev(8'h1C, 1'b0, 1'b0);
    send_byte(8'h1C);
    total++;
    if (key_down !== 1'b1) begin bad++; $display("FAIL mb_key_down_set got %0b want 1", key_down); end
    push_ev(8'h1C, 1'b0, 1'b1);
    send_byte(8'hF0);
    send_byte(8'h1C);
    total++;
    if (key_down !== 1'b0) begin bad++; $display("FAIL mb_key_down_clr got %0b want 0", key_down); end
    total++;
    if (press_cnt !== 8'd1) begin bad++; $display("FAIL mb_press_cnt got %0d want 1", press_cnt); end
    drain("make_break");
  endtask

  task automatic test_ext();
    push_ev(8'h75, 1'b1, 1'b0);
    push_ev(8'h75, 1'b1, 1'b1);
    send_byte(8'hE0); send_byte(8'h75);
    total++;
    if (key_down !== 1'b1) begin bad++; $display("FAIL ext_key_down_set got %0b want 1", key_down); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    total++;
    if (key_down !== 1'b0) begin bad++; $display("FAIL ext_key_down_clr got %0b want 0", key_down); end
    total++;
    if (press_cnt !== exp_cnt) begin bad++; $display("FAIL ext_press_cnt got %0d want %0d", press_cnt, exp_cnt); end
    drain("ext");
  endtask

  task automatic test_typematic();
`ifdef PS2_TYPEMATIC_FILTER_EN
    push_ev(8'h29, 1'b0, 1'b0);
`else
    push_ev(8'h29, 1'b0, 1'b0);
    push_ev(8'h29, 1'b0, 1'b0);
    push_ev(8'h29, 1'b0, 1'b0);
`endif
    push_ev(8'h29, 1'b0, 1'b1);
    send_byte(8'h29); send_byte(8'h29); send_byte(8'h29);
    total++;
    if (press_cnt !== exp_cnt) begin bad++; $display("FAIL typ_press_cnt got %0d want %0d", press_cnt, exp_cnt); end
    send_byte(8'hF0); send_byte(8'h29);
    total++;
    if (key_down !== 1'b0) begin bad++; $display("FAIL typ_key_down got %0b want 0", key_down); end
    drain("typematic");
  endtask

  task automatic test_err();
    // F0 E0: error, back to IDLE, next plain byte is a make.
    push_err();
    push_ev(8'h16, 1'b0, 1'b0);
    send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h16);
    // E0 E0: error but stays extended.
    push_err();
    push_ev(8'h5A, 1'b1, 1'b0);
    send_byte(8'hE0); send_byte(8'hE0); send_byte(8'h5A);
    // Non-matching break leaves key_down set.
    push_ev(8'h16, 1'b0, 1'b1);
    send_byte(8'hF0); send_byte(8'h16);
    total++;
    if (key_down !== 1'b1) begin bad++; $display("FAIL err_nonmatch_key_down got %0b want 1", key_down); end
    push_ev(8'h5A, 1'b1, 1'b1);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h5A);
    total++;
    if (key_down !== 1'b0) begin bad++; $display("FAIL err_match_key_down got %0b want 0", key_down); end
    // E0 F0 F0: error from the extended-break state.
    push_err();
    push_ev(8'h1C, 1'b0, 1'b0);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'hF0); send_byte(8'h1C);
    push_ev(8'h1C, 1'b0, 1'b1);
    send_byte(8'hF0); send_byte(8'h1C);
    total++;
    if (press_cnt !== exp_cnt) begin bad++; $display("FAIL err_press_cnt got %0d want %0d", press_cnt, exp_cnt); end
    drain("err");
  endtask

  task automatic test_wrap();
    logic [7:0] code;
    logic       ext;
    logic       seen_wrap;
    seen_wrap = 1'b0;
    for (int k = 0; k < 256; k++) begin
      code = 8'(k);
      ext  = 1'b0;
      if (code == 8'hE0 || code == 8'hF0) begin
        ext  = 1'b1;
        code = code ^ 8'h01;
      end
      push_ev(code, ext, 1'b0);
      if (ext) send_byte(8'hE0);
      send_byte(code);
      if (exp_cnt == 8'd0) seen_wrap = 1'b1;
      total++;
      if (press_cnt !== exp_cnt) begin bad++; $display("FAIL wrap_press_cnt k=%0d got %h want %h", k, press_cnt, exp_cnt); end
      push_ev(code, ext, 1'b1);
      if (ext) send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(code);
    end
    total++;
    if (seen_wrap !== 1'b1 || key_down !== 1'b0) begin
      bad++;
      $display("FAIL wrap_end got wrapped=%0b key_down=%0b want 1 0", seen_wrap, key_down);
    end
    drain("wrap");
  endtask

  task automatic test_reset_mid();
    send_byte(8'hE0);
    resetn   = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h1C;
    @(negedge clk);
    total++;
    if ({ev_valid, err, ev_code, ev_ext, ev_break, ascii, key_down, press_cnt} !== 29'd0) begin
      bad++;
      $display("FAIL midreset_outputs got v=%0b err=%0b code=%h ext=%0b brk=%0b ascii=%h kd=%0b cnt=%h want all 0",
               ev_valid, err, ev_code, ev_ext, ev_break, ascii, key_down, press_cnt);
    end
    in_valid = 1'b0;
    resetn   = 1'b1;
    exp_cnt  = 8'd0;
    push_ev(8'h1C, 1'b0, 1'b0);
    send_byte(8'h1C);
    total++;
    if (press_cnt !== 8'd1 || key_down !== 1'b1) begin
      bad++;
      $display("FAIL midreset_make got cnt=%0d kd=%0b want 1 1", press_cnt, key_down);
    end
    drain("reset_mid");
  endtask

  initial begin
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    exp_cnt  = 8'd0;
    @(negedge clk);
    test_reset();
    test_make_break();
    test_ext();
    test_typematic();
    test_err();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the make-event counter press_cnt.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  one-cycle strobe: in_data holds a received PS/2 set-2 byte (checked frame, from the PS/2 receiver).
REQ-005 SHALL have port in_data  input  8  received byte, sampled only when in_valid=1.
REQ-006 SHALL have port ev_valid  output  1  one-cycle key-event strobe.
REQ-007 SHALL have port ev_code  output  8  scan code of the event (prefixes stripped), held until next event.
REQ-008 SHALL have port ev_ext  output  1  event carried an E0 prefix.
REQ-009 SHALL have port ev_break  output  1  event is a release (F0 prefix), else press.
REQ-010 SHALL have port ascii  output  8  ASCII of ev_code, held with ev_code.
REQ-011 SHALL have port key_down  output  1  a key is currently held.
REQ-012 SHALL have port press_cnt  output  CNT_W  number of counted make events, modulo 2^CNT_W.
REQ-013 SHALL have port err  output  1  one-cycle strobe on an illegal prefix sequence.

Function
REQ-014 SHALL implement FSM states IDLE, EXT, BRK, EXT_BRK; transitions only on in_valid=1 cycles.
REQ-015 IDLE: E0->EXT; F0->BRK; other byte->make event (ext=0), stay IDLE.
REQ-016 EXT: F0->EXT_BRK; E0->err pulse, stay EXT; other byte->make event (ext=1), ->IDLE.
REQ-017 BRK: E0 or F0->err pulse, ->IDLE, no event; other byte->break event (ext=0), ->IDLE.
REQ-018 EXT_BRK: E0 or F0->err pulse, ->IDLE, no event; other byte->break event (ext=1), ->IDLE.
REQ-019 All outputs SHALL be registered; ev_valid/err assert in the cycle after the in_valid cycle carrying the final byte (latency 1).
REQ-020 ev_code/ev_ext/ev_break/ascii SHALL update only together with ev_valid=1.
REQ-021 ascii SHALL map non-ext set-2 codes: A..Z -> 0x41..0x5A (1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A), 0..9 -> 0x30..0x39 (45,16,1E,26,25,2E,36,3D,3E,46), 29->0x20, 5A->0x0D; all other codes and every ext event -> 0x00.
REQ-022 Internal held-key register {code,ext}: make event loads it and sets key_down; break event whose {code,ext} equals held key clears key_down; non-matching break leaves key_down unchanged.
REQ-023 Each counted make event SHALL increment press_cnt by 1, wrapping 2^CNT_W-1 -> 0; break events never count.
REQ-024 in_valid held high on consecutive cycles SHALL process one byte per cycle with no loss.
REQ-025 An in_valid byte in any state other than those listed SHALL be impossible (full decode, no latent states); unused encodings recover to IDLE.

Reset
REQ-026 resetn=0 at a clk edge SHALL force state IDLE, ev_valid=0, err=0, ev_code=0, ev_ext=0, ev_break=0, ascii=0, key_down=0, press_cnt=0, held key=0.
REQ-027 Reset mid-sequence (after E0/F0) SHALL discard the pending prefix; an in_valid byte during reset is ignored.

Configuration
REQ-028 Macro PS2_TYPEMATIC_FILTER_EN defined: a make event whose {code,ext} equals the held key while key_down=1 SHALL produce no ev_valid and no press_cnt increment (auto-repeat suppressed).
REQ-029 Macro undefined: every make event, including auto-repeat, SHALL pulse ev_valid and increment press_cnt.

Verification
REQ-030 Bytes 1C, F0, 1C -> ev(1C,ext0,brk0,ascii 0x41), then ev(1C,ext0,brk1); key_down 1 then 0; press_cnt=1.
REQ-031 Bytes E0, 75, E0, F0, 75 -> ev(75,ext1,brk0,ascii 0x00), ev(75,ext1,brk1); key_down ends 0.
REQ-032 Bytes 29 x3 then F0,29 -> with filter: 1 make event, press_cnt=1; without: 3 make events, press_cnt=3; both end key_down=0.
REQ-033 Bytes F0, E0 -> err pulse 1 cycle after E0, no ev_valid, state IDLE (next byte 16 -> make, ascii 0x31).
REQ-034 256 distinct-key make/break pairs (CNT_W=8) -> press_cnt wraps FF->00.
REQ-035 Byte E0, then resetn=0 one cycle, then 1C -> make event with ev_ext=0, all outputs zero during reset.
